arm_decode_stage: RTL and testbench

Parametrised decode stage with an integrated ID/EX pipeline register for the ARM core. It decodes the fetched instruction and reads operands from an internal register file with write-through bypass. It detects read-after-write hazards in either forwarding or non-forwarding mode and presents a registered, bubble-capable bundle to the EX stage. It replaces the combinational decode plus separate ID/EX register pair.

---
 rtl/arm_decode_if.sv | 47 ++++
 rtl/arm_decode_stage.sv | 213 +++++++++++++++++++++
 tb/tb_arm_decode_stage.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_decode_if.sv
// IF-to-ID handshake and registered ID/EX bundle between the decode stage and its neighbours.
interface arm_decode_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned EXE_CMD_W = 4
);
  localparam int unsigned REG_AW = $clog2(NUM_REGS);

  logic                 if_valid;
  logic [ADDR_W-1:0]    if_pc;
  logic [31:0]          if_instr;
  logic                 if_stall;

  logic                 id_valid;
  logic [ADDR_W-1:0]    id_pc;
  logic                 id_mem_read;
  logic                 id_mem_write;
  logic                 id_wb_en;
  logic                 id_branch;
  logic                 id_s_en;
  logic [EXE_CMD_W-1:0] id_exe_cmd;
  logic [DATA_W-1:0]    id_val_rn;
  logic [DATA_W-1:0]    id_val_rm;
  logic [REG_AW-1:0]    id_src1;
  logic [REG_AW-1:0]    id_src2;
  logic [REG_AW-1:0]    id_dest;
  logic                 id_imm;
  logic [11:0]          id_shift_op;
  logic [23:0]          id_simm24;

  modport master (
    output if_valid, if_pc, if_instr,
    input  if_stall,
    input  id_valid, id_pc, id_mem_read, id_mem_write, id_wb_en, id_branch, id_s_en,
           id_exe_cmd, id_val_rn, id_val_rm, id_src1, id_src2, id_dest, id_imm,
           id_shift_op, id_simm24
  );

  modport slave (
    input  if_valid, if_pc, if_instr,
    output if_stall,
    output id_valid, id_pc, id_mem_read, id_mem_write, id_wb_en, id_branch, id_s_en,
           id_exe_cmd, id_val_rn, id_val_rm, id_src1, id_src2, id_dest, id_imm,
           id_shift_op, id_simm24
  );
endinterface

// File: rtl/arm_decode_stage.sv
// ARM decode stage: control decode, condition check, bypassed register file,
// RAW hazard detection and the ID/EX pipeline register.
module arm_decode_stage #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned NUM_REGS      = 16,
  parameter int unsigned EXE_CMD_W     = 4,
  parameter bit          FORWARDING_EN = 1'b1,
  localparam int unsigned REG_AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  arm_decode_if.slave       bus,
  input  logic [3:0]        status_in,
  input  logic              flush,
  input  logic              ex_freeze,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              exe_wb_en,
  input  logic              exe_mem_read,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              wb_en
);

  typedef struct packed {
    logic                 valid;
    logic [ADDR_W-1:0]    pc;
    logic                 mem_read;
    logic                 mem_write;
    logic                 wb_en;
    logic                 branch;
    logic                 s_en;
    logic [EXE_CMD_W-1:0] exe_cmd;
    logic [DATA_W-1:0]    val_rn;
    logic [DATA_W-1:0]    val_rm;
    logic [REG_AW-1:0]    src1;
    logic [REG_AW-1:0]    src2;
    logic [REG_AW-1:0]    dest;
    logic                 imm;
    logic [11:0]          shift_op;
    logic [23:0]          simm24;
  } id_bundle_t;

  logic [31:0] instr;
  logic [1:0]  mode;
  logic [3:0]  opcode;
  logic        s_bit;

  logic                 dec_mem_read, dec_mem_write, dec_wb_en, dec_branch, dec_s_en;
  logic [EXE_CMD_W-1:0] dec_exe_cmd;

  logic [REG_AW-1:0] src1, src2;
  logic              two_src;
  logic              cond_ok;
  logic              hazard_raw, hazard;
  logic [DATA_W-1:0] val_rn, val_rm;

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  id_bundle_t        bundle_q, bundle_d;

  assign instr  = bus.if_instr;
  assign mode   = instr[27:26];
  assign opcode = instr[24:21];
  assign s_bit  = instr[20];

  // Control unit: data-processing, load/store and branch classes.
  always_comb begin
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_wb_en     = 1'b0;
    dec_branch    = 1'b0;
    dec_s_en      = 1'b0;
    dec_exe_cmd   = '0;
    case (mode)
      2'b00: begin
        dec_s_en = s_bit;
        case (opcode)
          4'b1101: begin dec_exe_cmd = EXE_CMD_W'(4'b0001); dec_wb_en = 1'b1; end
          4'b1111: begin dec_exe_cmd = EXE_CMD_W'(4'b1001); dec_wb_en = 1'b1; end
          4'b0100: begin dec_exe_cmd = EXE_CMD_W'(4'b0010); dec_wb_en = 1'b1; end
          4'b0101: begin dec_exe_cmd = EXE_CMD_W'(4'b0011); dec_wb_en = 1'b1; end
          4'b0010: begin dec_exe_cmd = EXE_CMD_W'(4'b0100); dec_wb_en = 1'b1; end
          4'b0110: begin dec_exe_cmd = EXE_CMD_W'(4'b0101); dec_wb_en = 1'b1; end
          4'b0000: begin dec_exe_cmd = EXE_CMD_W'(4'b0110); dec_wb_en = 1'b1; end
          4'b1100: begin dec_exe_cmd = EXE_CMD_W'(4'b0111); dec_wb_en = 1'b1; end
          4'b0001: begin dec_exe_cmd = EXE_CMD_W'(4'b1000); dec_wb_en = 1'b1; end
          4'b1010: dec_exe_cmd = EXE_CMD_W'(4'b0100);
          4'b1000: dec_exe_cmd = EXE_CMD_W'(4'b0110);
          default: dec_exe_cmd = '0;
        endcase
      end
      2'b01: begin
        dec_exe_cmd = EXE_CMD_W'(4'b0010);
        if (s_bit) begin
          dec_mem_read = 1'b1;
          dec_wb_en    = 1'b1;
        end else begin
          dec_mem_write = 1'b1;
        end
      end
      2'b10:   dec_branch = 1'b1;
      default: dec_branch = 1'b0;
    endcase
  end

  // Condition check against NZCV = status_in[3:0].
  always_comb begin
    case (instr[31:28])
      4'h0:    cond_ok = status_in[2];
      4'h1:    cond_ok = ~status_in[2];
      4'h2:    cond_ok = status_in[1];
      4'h3:    cond_ok = ~status_in[1];
      4'h4:    cond_ok = status_in[3];
      4'h5:    cond_ok = ~status_in[3];
      4'h6:    cond_ok = status_in[0];
      4'h7:    cond_ok = ~status_in[0];
      4'h8:    cond_ok = status_in[1] & ~status_in[2];
      4'h9:    cond_ok = ~status_in[1] | status_in[2];
      4'hA:    cond_ok = (status_in[3] == status_in[0]);
      4'hB:    cond_ok = (status_in[3] != status_in[0]);
      4'hC:    cond_ok = ~status_in[2] & (status_in[3] == status_in[0]);
      4'hD:    cond_ok = status_in[2] | (status_in[3] != status_in[0]);
      4'hE:    cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign src1    = REG_AW'(instr[19:16]);
  assign src2    = dec_mem_write ? REG_AW'(instr[15:12]) : REG_AW'(instr[3:0]);
  assign two_src = ~instr[25] | dec_mem_write;

  // Register file with write-through bypass on the read ports.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[wb_dest] <= wb_value;
    end
  end

  assign val_rn = (wb_en && wb_dest == src1) ? wb_value : rf_q[src1];
  assign val_rm = (wb_en && wb_dest == src2) ? wb_value : rf_q[src2];

  always_comb begin
    if (FORWARDING_EN) begin
      hazard_raw = exe_mem_read & ((src1 == exe_dest) | (two_src & (src2 == exe_dest)));
    end else begin
      hazard_raw = (exe_wb_en & (src1 == exe_dest)) | (mem_wb_en & (src1 == mem_dest)) |
                   (two_src & ((exe_wb_en & (src2 == exe_dest)) |
                               (mem_wb_en & (src2 == mem_dest))));
    end
  end

  // Gated by reset so that if_stall comes out of reset low.
  assign hazard       = bus.if_valid & rst & hazard_raw;
  assign bus.if_stall = (hazard & ~flush) | ex_freeze;

  // ID/EX next value: flush > freeze > hazard/invalid bubble > condition-failed > full load.
  always_comb begin
    bundle_d = '0;
    if (flush) begin
      bundle_d = '0;
    end else if (ex_freeze) begin
      bundle_d = bundle_q;
    end else if (hazard || !bus.if_valid) begin
      bundle_d = '0;
    end else begin
      bundle_d.valid    = 1'b1;
      bundle_d.pc       = bus.if_pc;
      bundle_d.val_rn   = val_rn;
      bundle_d.val_rm   = val_rm;
      bundle_d.src1     = src1;
      bundle_d.src2     = src2;
      bundle_d.dest     = REG_AW'(instr[15:12]);
      bundle_d.imm      = instr[25];
      bundle_d.shift_op = instr[11:0];
      bundle_d.simm24   = instr[23:0];
      if (cond_ok) begin
        bundle_d.mem_read  = dec_mem_read;
        bundle_d.mem_write = dec_mem_write;
        bundle_d.wb_en     = dec_wb_en;
        bundle_d.branch    = dec_branch;
        bundle_d.s_en      = dec_s_en;
        bundle_d.exe_cmd   = dec_exe_cmd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bundle_q <= '0;
    else      bundle_q <= bundle_d;
  end

  assign bus.id_valid     = bundle_q.valid;
  assign bus.id_pc        = bundle_q.pc;
  assign bus.id_mem_read  = bundle_q.mem_read;
  assign bus.id_mem_write = bundle_q.mem_write;
  assign bus.id_wb_en     = bundle_q.wb_en;
  assign bus.id_branch    = bundle_q.branch;
  assign bus.id_s_en      = bundle_q.s_en;
  assign bus.id_exe_cmd   = bundle_q.exe_cmd;
  assign bus.id_val_rn    = bundle_q.val_rn;
  assign bus.id_val_rm    = bundle_q.val_rm;
  assign bus.id_src1      = bundle_q.src1;
  assign bus.id_src2      = bundle_q.src2;
  assign bus.id_dest      = bundle_q.dest;
  assign bus.id_imm       = bundle_q.imm;
  assign bus.id_shift_op  = bundle_q.shift_op;
  assign bus.id_simm24    = bundle_q.simm24;

endmodule

// File: tb/tb_arm_decode_stage.sv
// Scoreboard bench for arm_decode_stage: one instance per forwarding mode, same stimulus.
module tb_arm_decode_stage;
  localparam int unsigned BW = 155;
  localparam logic [31:0] ADD   = 32'hE0821003;
  localparam logic [31:0] ADDEQ = 32'h00821003;
  localparam logic [31:0] SUB   = 32'hE0445006;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  logic [3:0]  status_in;
  logic        flush, ex_freeze;
  logic [3:0]  exe_dest, mem_dest, wb_dest;
  logic        exe_wb_en, exe_mem_read, mem_wb_en, wb_en;
  logic [31:0] wb_value;

  int    n_cmp = 0;
  int    n_err = 0;
  string cur   = "init";

  logic [31:0]   m_rf [16];
  logic [BW-1:0] q0 [$];
  logic [BW-1:0] q1 [$];
  logic [BW-1:0] prev0, prev1;
  logic [BW-1:0] obs0, obs1;

  always #5 clk = ~clk;

  arm_decode_if #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(16), .EXE_CMD_W(4)) bus0 ();
  arm_decode_if #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(16), .EXE_CMD_W(4)) bus1 ();

  assign bus0.if_valid = if_valid;
  assign bus0.if_pc    = if_pc;
  assign bus0.if_instr = if_instr;
  assign bus1.if_valid = if_valid;
  assign bus1.if_pc    = if_pc;
  assign bus1.if_instr = if_instr;

  arm_decode_stage #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(16), .EXE_CMD_W(4), .FORWARDING_EN(1'b0)) u_fwd0 (
    .clk(clk), .rst(rst), .bus(bus0), .status_in(status_in), .flush(flush), .ex_freeze(ex_freeze),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .wb_dest(wb_dest), .wb_value(wb_value), .wb_en(wb_en)
  );

  arm_decode_stage #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(16), .EXE_CMD_W(4), .FORWARDING_EN(1'b1)) u_fwd1 (
    .clk(clk), .rst(rst), .bus(bus1), .status_in(status_in), .flush(flush), .ex_freeze(ex_freeze),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .wb_dest(wb_dest), .wb_value(wb_value), .wb_en(wb_en)
  );

  assign obs0 = {bus0.id_valid, bus0.id_pc, bus0.id_mem_read, bus0.id_mem_write, bus0.id_wb_en,
                 bus0.id_branch, bus0.id_s_en, bus0.id_exe_cmd, bus0.id_val_rn, bus0.id_val_rm,
                 bus0.id_src1, bus0.id_src2, bus0.id_dest, bus0.id_imm, bus0.id_shift_op, bus0.id_simm24};
  assign obs1 = {bus1.id_valid, bus1.id_pc, bus1.id_mem_read, bus1.id_mem_write, bus1.id_wb_en,
                 bus1.id_branch, bus1.id_s_en, bus1.id_exe_cmd, bus1.id_val_rn, bus1.id_val_rm,
                 bus1.id_src1, bus1.id_src2, bus1.id_dest, bus1.id_imm, bus1.id_shift_op, bus1.id_simm24};

  task automatic check_val(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s/%s: observed %h, expected %h", cur, tag, obs, exp);
    end
  endtask

  // Reference: {mem_read, mem_write, wb_en, branch, s_en, exe_cmd[3:0]}
  function automatic logic [8:0] m_ctrl(input logic [31:0] ins);
    logic [4:0] dp;
    case (ins[24:21])
      4'hD: dp = 5'b1_0001;  4'hF: dp = 5'b1_1001;
      4'h4: dp = 5'b1_0010;  4'h5: dp = 5'b1_0011;
      4'h2: dp = 5'b1_0100;  4'h6: dp = 5'b1_0101;
      4'h0: dp = 5'b1_0110;  4'hC: dp = 5'b1_0111;
      4'h1: dp = 5'b1_1000;  4'hA: dp = 5'b0_0100;
      4'h8: dp = 5'b0_0110;  default: dp = 5'b0_0000;
    endcase
    case (ins[27:26])
      2'b00:   return {2'b00, dp[4], 1'b0, ins[20], dp[3:0]};
      2'b01:   return ins[20] ? 9'b1_0_1_0_0_0010 : 9'b0_1_0_0_0_0010;
      2'b10:   return 9'b0_0_0_1_0_0000;
      default: return 9'd0;
    endcase
  endfunction

  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] nzcv);
    bit n, z, cy, v;
    {n, z, cy, v} = nzcv;
    case (c)
      0: return z;        1: return !z;       2: return cy;          3: return !cy;
      4: return n;        5: return !n;       6: return v;           7: return !v;
      8: return cy && !z; 9: return !cy || z; 10: return n == v;     11: return n != v;
      12: return !z && (n == v);  13: return z || (n != v);  14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_rd(input logic [3:0] a);
    return (wb_en && wb_dest == a) ? wb_value : m_rf[a];
  endfunction

  function automatic bit m_hazard(input bit fwd);
    logic [3:0] s1, s2;
    bit mw, two, e1, e2, m1, m2;
    mw  = m_ctrl(if_instr)[7];
    s1  = if_instr[19:16];
    s2  = mw ? if_instr[15:12] : if_instr[3:0];
    two = !if_instr[25] || mw;
    if (!rst || !if_valid) return 1'b0;
    if (fwd) return exe_mem_read && (s1 == exe_dest || (two && s2 == exe_dest));
    e1 = exe_wb_en && s1 == exe_dest;  e2 = exe_wb_en && s2 == exe_dest;
    m1 = mem_wb_en && s1 == mem_dest;  m2 = mem_wb_en && s2 == mem_dest;
    return e1 || m1 || (two && (e2 || m2));
  endfunction

  function automatic logic [BW-1:0] m_bundle(input bit fwd, input logic [BW-1:0] prev);
    logic [8:0] ctl;
    logic [3:0] s2;
    if (!rst || flush) return '0;
    if (ex_freeze) return prev;
    if (m_hazard(fwd) || !if_valid) return '0;
    ctl = m_ctrl(if_instr);
    s2  = ctl[7] ? if_instr[15:12] : if_instr[3:0];
    if (!m_cond(if_instr[31:28], status_in)) ctl = '0;
    return {1'b1, if_pc, ctl, m_rd(if_instr[19:16]), m_rd(s2), if_instr[19:16], s2,
            if_instr[15:12], if_instr[25], if_instr[11:0], if_instr[23:0]};
  endfunction

  // One clock: check if_stall mid-cycle, queue expected bundles, compare after the edge.
  task automatic cycle();
    logic [BW-1:0] e0, e1;
    @(negedge clk);
    check_val("stall_fwd0", BW'(bus0.if_stall), BW'((m_hazard(1'b0) && !flush) || ex_freeze));
    check_val("stall_fwd1", BW'(bus1.if_stall), BW'((m_hazard(1'b1) && !flush) || ex_freeze));
    q0.push_back(m_bundle(1'b0, prev0));
    q1.push_back(m_bundle(1'b1, prev1));
    @(posedge clk);
    #1;
    if (rst && wb_en) m_rf[wb_dest] = wb_value;
    if (q0.size() == 0 || q1.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s/scoreboard: observed empty queue, expected entry", cur);
    end else begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      check_val("bundle_fwd0", obs0, e0);
      check_val("bundle_fwd1", obs1, e1);
      prev0 = e0;
      prev1 = e1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    prev0 = '0;
    prev1 = '0;
  endtask

  task automatic check_reset_now();
    check_val("rst_out_fwd0",   obs0, '0);
    check_val("rst_out_fwd1",   obs1, '0);
    check_val("rst_stall_fwd0", BW'(bus0.if_stall), '0);
    check_val("rst_stall_fwd1", BW'(bus1.if_stall), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish within bound");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst = 1'b0; if_valid = 1'b1; if_pc = 32'h100; if_instr = ADD; status_in = 4'h0;
    flush = 1'b0; ex_freeze = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0; wb_dest = 4'd0; wb_value = '0; wb_en = 1'b0;
    #2;
    cur = "reset";
    check_reset_now();
    @(posedge clk); #1;
    rst = 1'b1;

    cur = "rf_zero";      cycle();
    cur = "wb_r2";        if_valid = 1'b0; wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'd5; cycle();
    cur = "wb_r3";        wb_dest = 4'd3; wb_value = 32'd7; cycle();
    cur = "add";          wb_en = 1'b0; if_valid = 1'b1; if_pc = 32'h104; cycle();
    cur = "exe_raw";      exe_dest = 4'd2; exe_wb_en = 1'b1; cycle(); cycle();
    cur = "exe_raw_done"; exe_wb_en = 1'b0; cycle();
    cur = "mem_raw";      mem_dest = 4'd3; mem_wb_en = 1'b1; cycle();
    cur = "mem_raw_done"; mem_wb_en = 1'b0; cycle();
    cur = "load_use";     exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_read = 1'b1; cycle();
    cur = "load_use_done"; exe_mem_read = 1'b0; exe_wb_en = 1'b0; cycle();
    cur = "addeq_z0";     if_instr = ADDEQ; status_in = 4'b0000; cycle();
    cur = "addeq_z1";     status_in = 4'b0100; cycle();
    cur = "bypass";       if_instr = ADD; wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'hDEAD; cycle();
    cur = "bypass_rf";    wb_en = 1'b0; cycle();
    cur = "flush_hazard"; exe_dest = 4'd2; exe_wb_en = 1'b1; flush = 1'b1; cycle();
    cur = "freeze";       flush = 1'b0; exe_wb_en = 1'b0; if_instr = SUB; if_pc = 32'h200; ex_freeze = 1'b1; cycle(); cycle();
    cur = "flush_freeze"; flush = 1'b1; cycle();
    cur = "resume";       flush = 1'b0; ex_freeze = 1'b0; cycle();

    cur = "random";
    for (int i = 0; i < 40; i++) begin
      if_instr     = $urandom();
      if_pc        = $urandom();
      if_valid     = ($urandom_range(0, 7) != 0);
      status_in    = 4'($urandom());
      flush        = ($urandom_range(0, 7) == 0);
      ex_freeze    = ($urandom_range(0, 7) == 0);
      exe_dest     = 4'($urandom());
      exe_wb_en    = 1'($urandom());
      exe_mem_read = 1'($urandom());
      mem_dest     = 4'($urandom());
      mem_wb_en    = 1'($urandom());
      wb_dest      = 4'($urandom());
      wb_value     = $urandom();
      wb_en        = 1'($urandom());
      cycle();
    end

    cur = "stall_pre_rst";
    if_instr = ADD; if_valid = 1'b1; if_pc = 32'h300; flush = 1'b0; ex_freeze = 1'b0;
    wb_en = 1'b0; mem_wb_en = 1'b0; exe_wb_en = 1'b1; exe_mem_read = 1'b1; exe_dest = 4'd3;
    cycle();
    cur = "rst_mid_stall";
    rst = 1'b0;
    #1;
    check_reset_now();
    model_reset();
    cycle();
    rst = 1'b1;
    cur = "post_rst";     exe_mem_read = 1'b0; exe_wb_en = 1'b0; cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
